// File: rtl/bram_dwc_down.sv
// rtl/bram_dwc_down.sv - wide-to-narrow BRAM width converter (optional write-beat skip: BRAM_DWC_DOWN_WR_SKIP_EN)
module bram_dwc_down #(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 128,
    parameter int SLV_DATA_BITW = 32
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic                       ReqValid_SI,
    output logic                       ReqReady_SO,
    input  logic [ADDR_BITW-1:0]       ReqAddr_SI,
    input  logic [MST_DATA_BITW/8-1:0] ReqWrEn_SI,
    input  logic [MST_DATA_BITW-1:0]   ReqWr_DI,
    output logic                       RspValid_SO,
    input  logic                       RspReady_SI,
    output logic [MST_DATA_BITW-1:0]   Rd_DO,
    output logic                       BramEn_SO,
    output logic [ADDR_BITW-1:0]       BramAddr_SO,
    output logic [SLV_DATA_BITW/8-1:0] BramWrEn_SO,
    output logic [SLV_DATA_BITW-1:0]   BramWr_DO,
    input  logic [SLV_DATA_BITW-1:0]   BramRd_DI
);
    localparam int N       = MST_DATA_BITW / SLV_DATA_BITW;
    localparam int MST_OFF = $clog2(MST_DATA_BITW / 8);
    localparam int SLV_OFF = $clog2(SLV_DATA_BITW / 8);
    localparam int MST_SB  = MST_DATA_BITW / 8;
    localparam int SLV_SB  = SLV_DATA_BITW / 8;
    localparam int BW      = $clog2(N);

    typedef logic [BW-1:0] beat_t;
    localparam beat_t LAST_BEAT = beat_t'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITW-1:0]   base_q, base_d;
    logic [MST_SB-1:0]      strb_q, strb_d;
    logic [MST_DATA_BITW-1:0] data_q, data_d;
    logic                   is_wr_q, is_wr_d;
    beat_t                  beat_q, beat_d;
    logic [MST_DATA_BITW-1:0] rd_q, rd_d;

`ifdef BRAM_DWC_DOWN_WR_SKIP_EN
    logic [BW:0] nz;

    // Lowest beat index >= from whose strobe slice is non-zero; MSB flags a hit.
    function automatic logic [BW:0] next_nz(input logic [MST_SB-1:0] strb, input int from);
        logic [BW:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i >= from && |strb[i*SLV_SB +: SLV_SB]) begin
                res = {1'b1, beat_t'(i)};
            end
        end
        return res;
    endfunction
`endif

    // State register and latched request; async active-low reset aborts any transaction.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            base_q  <= '0;
            strb_q  <= '0;
            data_q  <= '0;
            is_wr_q <= 1'b0;
            beat_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
            is_wr_q <= is_wr_d;
            beat_q  <= beat_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state: latch request, step beats, gather read slices one cycle behind each beat.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        strb_d  = strb_q;
        data_d  = data_q;
        is_wr_d = is_wr_q;
        beat_d  = beat_q;
        rd_d    = rd_q;
`ifdef BRAM_DWC_DOWN_WR_SKIP_EN
        nz      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (ReqValid_SI) begin
                    base_d  = ReqAddr_SI >> MST_OFF;
                    strb_d  = ReqWrEn_SI;
                    data_d  = ReqWr_DI;
                    is_wr_d = |ReqWrEn_SI;
                    beat_d  = '0;
                    state_d = ISSUE;
`ifdef BRAM_DWC_DOWN_WR_SKIP_EN
                    if (|ReqWrEn_SI) begin
                        nz     = next_nz(ReqWrEn_SI, 0);
                        beat_d = nz[BW-1:0];
                    end
`endif
                end
            end
            ISSUE: begin
                // Data of the previous read beat is on BramRd_DI now.
                if (!is_wr_q && beat_q != '0) begin
                    rd_d[(int'(beat_q) - 1)*SLV_DATA_BITW +: SLV_DATA_BITW] = BramRd_DI;
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = is_wr_q ? RESP : WAIT_RD;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
`ifdef BRAM_DWC_DOWN_WR_SKIP_EN
                if (is_wr_q) begin
                    nz = next_nz(strb_q, int'(beat_q) + 1);
                    if (nz[BW]) begin
                        beat_d  = nz[BW-1:0];
                        state_d = ISSUE;
                    end else begin
                        beat_d  = '0;
                        state_d = RESP;
                    end
                end
`endif
            end
            WAIT_RD: begin
                rd_d[(N-1)*SLV_DATA_BITW +: SLV_DATA_BITW] = BramRd_DI;
                state_d = RESP;
            end
            RESP: begin
                if (RspReady_SI) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ReqReady_SO = (state_q == IDLE);
    assign RspValid_SO = (state_q == RESP);
    assign Rd_DO       = rd_q;
    assign BramEn_SO   = (state_q == ISSUE);
    assign BramAddr_SO = ADDR_BITW'((base_q * ADDR_BITW'(N) + ADDR_BITW'(beat_q)) << SLV_OFF);
    assign BramWrEn_SO = (state_q == ISSUE) ? strb_q[int'(beat_q)*SLV_SB +: SLV_SB] : '0;
    assign BramWr_DO   = (state_q == ISSUE) ? data_q[int'(beat_q)*SLV_DATA_BITW +: SLV_DATA_BITW] : '0;
endmodule

// File: tb/tb_bram_dwc_down.sv
// tb/tb_bram_dwc_down.sv - scoreboard bench for bram_dwc_down
module tb_bram_dwc_down;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic [15:0]  req_wren = '0;
    logic [127:0] req_wr = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [127:0] rd;
    logic         bram_en;
    logic [31:0]  bram_addr;
    logic [3:0]   bram_wren;
    logic [31:0]  bram_wr;
    logic [31:0]  bram_rd = '0;

    bram_dwc_down dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(req_valid), .ReqReady_SO(req_ready), .ReqAddr_SI(req_addr),
        .ReqWrEn_SI(req_wren), .ReqWr_DI(req_wr),
        .RspValid_SO(rsp_valid), .RspReady_SI(rsp_ready), .Rd_DO(rd),
        .BramEn_SO(bram_en), .BramAddr_SO(bram_addr), .BramWrEn_SO(bram_wren),
        .BramWr_DO(bram_wr), .BramRd_DI(bram_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
    } beat_t;

    beat_t        exp_beats[$];
    logic [127:0] exp_rsp[$];
    logic [127:0] last_rd = '0;
    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [31:0]  mem [logic [31:0]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Narrow BRAM model: one-cycle read latency, byte-merged writes.
    always @(posedge clk) begin
        if (bram_en) begin
            logic [31:0] old;
            old = mem.exists(bram_addr) ? mem[bram_addr] : 32'h0;
            bram_rd <= old;
            for (int b = 0; b < 4; b++) if (bram_wren[b]) old[b*8 +: 8] = bram_wr[b*8 +: 8];
            mem[bram_addr] = old;
        end
    end

    // Monitor: compare every BRAM beat and every response handshake against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bram_en) begin
                    if (exp_beats.size() == 0) begin
                        total_cnt++;
                        $display("FAIL beat_unexpected: got addr %h we %h, expected no beat", bram_addr, bram_wren);
                    end else begin
                        beat_t b;
                        b = exp_beats.pop_front();
                        check("beat_addr", 128'(bram_addr), 128'(b.addr));
                        check("beat_wren", 128'(bram_wren), 128'(b.we));
                        check("beat_wdata", 128'(bram_wr), 128'(b.wd));
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        total_cnt++;
                        $display("FAIL rsp_unexpected: got %h, expected no response", rd);
                    end else begin
                        check("rsp_rd_data", rd, exp_rsp.pop_front());
                    end
                end
            end
        end
    end

    // Queue the expected narrow beats of one request; returns how many.
    task automatic push_beats(input logic [31:0] addr, input logic [15:0] strb,
                              input logic [127:0] data, input int maxk, output int n);
        beat_t b;
        n = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef BRAM_DWC_DOWN_WR_SKIP_EN
            if (strb != 16'h0 && strb[k*4 +: 4] == 4'h0) continue;
`endif
            b.addr = {addr[31:4], 4'h0} + 32'(k * 4);
            b.we   = strb[k*4 +: 4];
            b.wd   = data[k*32 +: 32];
            if (n < maxk) exp_beats.push_back(b);
            n++;
        end
    endtask

    // Wait for the request handshake with ReqValid already driven.
    task automatic accept_wait();
        logic rr;
        int   i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            rr = req_ready;
            @(posedge clk);
            #1;
            if (rr) break;
        end
        check("req_accepted", 128'(i < 40), 128'(1));
        req_valid = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [15:0] strb, input logic [127:0] data);
        req_addr  = addr;
        req_wren  = strb;
        req_wr    = data;
        req_valid = 1'b1;
        accept_wait();
    endtask

    // Counts cycles after the handshake; returns at the negedge where RspValid is first seen.
    task automatic wait_rsp(input string name, input int exp_cycle, input int exp_n);
        int first_en = 0, n_en = 0, first_rsp = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bram_en) begin
                n_en++;
                if (first_en == 0) first_en = c;
            end
            if (rsp_valid) begin
                first_rsp = c;
                break;
            end
        end
        check({name, "_first_beat_cycle"}, 128'(first_en), 128'(1));
        check({name, "_beat_count"}, 128'(n_en), 128'(exp_n));
        check({name, "_rsp_cycle"}, 128'(first_rsp), 128'(exp_cycle));
    endtask

    initial begin
        int n;
        logic [127:0] d;
        mem[32'h40]  = 32'h11111111; mem[32'h44]  = 32'h22222222;
        mem[32'h48]  = 32'h33333333; mem[32'h4C]  = 32'h44444444;
        mem[32'h100] = 32'h55555555; mem[32'h104] = 32'h66666666;
        mem[32'h108] = 32'h77777777; mem[32'h10C] = 32'h88888888;

        // Reset values
        #12;
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_bram_en", 128'(bram_en), 128'(0));
        check("rst_bram_wren", 128'(bram_wren), 128'(0));
        check("rst_bram_addr", 128'(bram_addr), 128'(0));
        check("rst_bram_wr", 128'(bram_wr), 128'(0));
        check("rst_rd", rd, 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write
        d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        push_beats(32'h20, 16'hFFFF, d, 4, n);
        exp_rsp.push_back(last_rd);
        send_req(32'h20, 16'hFFFF, d);
        wait_rsp("full_wr", 5, 4);
        @(posedge clk); #1;

        // Read with unaligned address
        push_beats(32'h4F, 16'h0, 128'h0, 4, n);
        last_rd = 128'h44444444_33333333_22222222_11111111;
        exp_rsp.push_back(last_rd);
        send_req(32'h4F, 16'h0, 128'h0);
        wait_rsp("read", 6, 4);
        @(posedge clk); #1;

        // Backpressure with a pending write
        rsp_ready = 1'b0;
        push_beats(32'h100, 16'h0, 128'h0, 4, n);
        send_req(32'h100, 16'h0, 128'h0);
        wait_rsp("bp_read", 6, 4);
        last_rd = 128'h88888888_77777777_66666666_55555555;
        exp_rsp.push_back(last_rd);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                req_addr = 32'h200; req_wren = 16'hFFFF;
                req_wr = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
                req_valid = 1'b1;
            end
            @(negedge clk);
            check("bp_rsp_valid", 128'(rsp_valid), 128'(1));
            check("bp_rd_stable", rd, last_rd);
            check("bp_req_ready", 128'(req_ready), 128'(0));
            check("bp_no_beat", 128'(bram_en), 128'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        push_beats(32'h200, 16'hFFFF, req_wr, 4, n);
        exp_rsp.push_back(last_rd);
        accept_wait();
        wait_rsp("bp_pending_wr", 5, 4);
        @(posedge clk); #1;

        // Partial write
        d = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
        push_beats(32'h0, 16'h0F00, d, 4, n);
        exp_rsp.push_back(last_rd);
        send_req(32'h0, 16'h0F00, d);
`ifdef BRAM_DWC_DOWN_WR_SKIP_EN
        wait_rsp("partial_wr", 2, 1);
`else
        wait_rsp("partial_wr", 5, 4);
`endif
        @(posedge clk); #1;

        // Reset during beat 2 of a write
        push_beats(32'h300, 16'hFFFF, d, 2, n);
        send_req(32'h300, 16'hFFFF, d);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        check("mid_beat2_en", 128'(bram_en), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_bram_en", 128'(bram_en), 128'(0));
        check("mid_rst_bram_wren", 128'(bram_wren), 128'(0));
        check("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("mid_rst_rd", rd, 128'(0));
        last_rd = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 128'(req_ready), 128'(1));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("aborted_no_rsp", 128'(n), 128'(0));
        @(posedge clk); #1;

        // Read back the full write
        push_beats(32'h20, 16'h0, 128'h0, 4, n);
        last_rd = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        exp_rsp.push_back(last_rd);
        send_req(32'h20, 16'h0, 128'h0);
        wait_rsp("readback", 6, 4);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        check("beats_drained", 128'(exp_beats.size()), 128'(0));
        check("rsps_drained", 128'(exp_rsp.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bram_dwc_down.md
Name: bram_dwc_down

Overview:
- Width converter for the wide-to-narrow direction: a wide master talks to a narrow BRAM slave.
- Each wide request, accepted by valid/ready handshake, is serialized into N consecutive narrow BRAM beats.
- For reads, the narrow read data is gathered into one wide word, returned on a valid/ready response channel.
- Sits between a wide DMA/AXI-to-BRAM bridge and a narrow on-chip BRAM port.

Parameters:
- ADDR_BITW, 32, byte-address width on both sides.
- MST_DATA_BITW, 128, wide (master) data width; integer multiple of SLV_DATA_BITW.
- SLV_DATA_BITW, 32, narrow (BRAM) data width; multiple of 8.
- Derived: N = MST_DATA_BITW/SLV_DATA_BITW (N >= 2); MST_OFF = clog2(MST_DATA_BITW/8); SLV_OFF = clog2(SLV_DATA_BITW/8).

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- ReqValid_SI  in  1  wide request valid.
- ReqReady_SO  out  1  wide request ready.
- ReqAddr_SI  in  ADDR_BITW  wide byte address.
- ReqWrEn_SI  in  MST_DATA_BITW/8  byte write strobes; all-zero means read.
- ReqWr_DI  in  MST_DATA_BITW  write data.
- RspValid_SO  out  1  response valid.
- RspReady_SI  in  1  response ready.
- Rd_DO  out  MST_DATA_BITW  assembled read data.
- BramEn_SO  out  1  BRAM enable.
- BramAddr_SO  out  ADDR_BITW  narrow byte address.
- BramWrEn_SO  out  SLV_DATA_BITW/8  narrow byte strobes.
- BramWr_DO  out  SLV_DATA_BITW  narrow write data.
- BramRd_DI  in  SLV_DATA_BITW  BRAM read data, valid one cycle after BramEn_SO.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; ReqReady_SO=1, RspValid_SO=0, BramEn_SO=0, BramWrEn_SO=0, BramAddr_SO=0, BramWr_DO=0, Rd_DO=0, beat counter 0.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: ReqReady_SO=1. When ReqValid_SI=1, latch addr/strobes/data, set kind = write if |ReqWrEn_SI, go to ISSUE.
- ISSUE: one beat per cycle, k=0..N-1.
  - BramEn_SO=1; BramAddr_SO = (((addr>>MST_OFF)*N + k) << SLV_OFF), truncated to ADDR_BITW. Addr bits below MST_OFF are ignored.
  - BramWrEn_SO = strobe slice k; BramWr_DO = data slice k (slice k = bits [k*SLV+SLV-1 : k*SLV]).
  - After the last beat: read goes to WAIT_RD, write goes to RESP.
- Read capture: BramRd_DI from beat k is registered into Rd_DO slice k in the cycle after beat k. WAIT_RD lasts one cycle, captures the last slice, then goes to RESP.
- RESP: RspValid_SO=1. Rd_DO and RspValid_SO are held stable until RspReady_SI=1, then go to IDLE.
  - Write responses leave Rd_DO unchanged.
- Throughput: no request overlap. ReqReady_SO=0 in all states except IDLE.
- Latency, handshake at cycle 0:
  - Beats in cycles 1..N.
  - Write: RspValid_SO from cycle N+1.
  - Read: RspValid_SO from cycle N+2.
- Outputs: all BRAM-side outputs and Rsp outputs come only from registers/state; no combinational path from Req* or RspReady_SI.
- BramEn_SO=0 and BramWrEn_SO=0 outside ISSUE.
- Reset mid-operation: transaction aborted, no response. BRAM outputs deassert immediately. ReqReady_SO=1 in the first cycle after release.
- ReqValid_SI while not in IDLE: ignored (not latched).

Optional Feature:
- Macro BRAM_DWC_DOWN_WR_SKIP_EN.
- Defined: in write transactions, beats whose strobe slice is all zero are skipped and consume no cycle. ISSUE jumps to the next beat with a non-zero slice, using a priority search. Write latency = (number of non-zero slices) + 1.
- Not defined: all N beats are issued. Zero-strobe beats drive BramEn_SO=1 and BramWrEn_SO=0, which is a harmless read.
- Reads are unaffected either way.

Test Plan:
- Reset check: assert Rst_RBI=0 mid-run, including at ISSUE beat 2 -> BramEn_SO=0 immediately; RspValid_SO=0, Rd_DO=0. ReqReady_SO=1 after release; the aborted request never responds.
- Full write: ReqAddr 0x20, ReqWrEn 0xFFFF, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> cycles 1-4: BramAddr 0x20/0x24/0x28/0x2C, BramWrEn 0xF, data AAAAAAAA..DDDDDDDD; RspValid_SO at cycle 5.
- Read: BRAM model preloaded with 0x40->0x11111111, 0x44->0x22222222, 0x48->0x33333333, 0x4C->0x44444444; ReqAddr 0x4F, ReqWrEn 0 -> beats at 0x40..0x4C; Rd_DO = 0x44444444_33333333_22222222_11111111 at cycle 6.
- Backpressure: complete a read with RspReady_SI=0 for 3 cycles -> RspValid_SO and Rd_DO stable; ReqReady_SO=0; a pending ReqValid_SI is accepted only after the response handshake.
- Partial write: ReqWrEn 0x0F00 at addr 0 -> only beat 2 (0x08) has BramWrEn 0xF.
  - Without macro: 4 beats, RspValid_SO at cycle 5.
  - With macro: 1 beat at cycle 1, RspValid_SO at cycle 2.
